// File: rtl/led_shift_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : led_shift_receiver
//  Purpose  : Receiver model of the LED-driver serial link: oversampled
//             deserializer, output latch, OE gating and per-frame on-time.
//  Revision : 1.0  initial release
// ============================================================================
module led_shift_receiver #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         serial_clk,
    input  logic                         serial_in,
    input  logic                         latch_enable,
    input  logic                         output_enable_n,
    output logic                         serial_chain_out,
    output logic [WIDTH-1:0]             latched,
    output logic [WIDTH-1:0]             led_on,
    output logic                         latch_strobe,
    output logic                         frame_error,
    output logic [$clog2(WIDTH+1):0]     bit_count,
    output logic [CNT_W-1:0]             on_cycles
);

    localparam int                c_BC_W    = $clog2(WIDTH + 1) + 1;
    localparam logic [c_BC_W-1:0] c_BC_MAX  = '1;
    localparam logic [c_BC_W-1:0] c_BC_FULL = c_BC_W'(WIDTH);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;

    logic [2:0]       r_sclk_sync;
    logic [1:0]       r_sdat_sync;
    logic [2:0]       r_le_sync;
    logic [1:0]       r_oen_sync;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_run_cnt;

    logic             w_shift;
    logic             w_latch;
    logic             w_oe_active;
    logic [CNT_W-1:0] w_run_next;

    // Data goes through the same two stages as the clock so that the sample
    // used on a detected rise is the value present at the link edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_sync <= 3'b000;
            r_sdat_sync <= 2'b00;
            r_le_sync   <= 3'b000;
            r_oen_sync  <= 2'b11;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], serial_clk};
            r_sdat_sync <= {r_sdat_sync[0], serial_in};
            r_le_sync   <= {r_le_sync[1:0], latch_enable};
            r_oen_sync  <= {r_oen_sync[0], output_enable_n};
        end
    end

    assign w_shift     = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_latch     = r_le_sync[1] & ~r_le_sync[2];
    assign w_oe_active = ~r_oen_sync[1];

    // Saturating run count including the current cycle when OE is active.
    assign w_run_next = (w_oe_active && (r_run_cnt != c_CNT_MAX))
                        ? r_run_cnt + CNT_W'(1) : r_run_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg <= '0;
        end else if (w_shift) begin
            r_shreg <= {r_shreg[WIDTH-2:0], r_sdat_sync[1]};
        end
    end

    assign serial_chain_out = r_shreg[WIDTH-1];

    // A latch coinciding with a shift captures the pre-shift register and
    // counts that shift as the first bit of the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            latched      <= '0;
            latch_strobe <= 1'b0;
            frame_error  <= 1'b0;
            bit_count    <= '0;
            on_cycles    <= '0;
            r_run_cnt    <= '0;
        end else begin
            latch_strobe <= w_latch;
            if (w_latch) begin
                latched     <= r_shreg;
                frame_error <= frame_error | (bit_count != c_BC_FULL);
                bit_count   <= w_shift ? c_BC_W'(1) : '0;
                on_cycles   <= w_run_next;
                r_run_cnt   <= '0;
            end else begin
                if (w_shift && (bit_count != c_BC_MAX)) begin
                    bit_count <= bit_count + c_BC_W'(1);
                end
                r_run_cnt <= w_run_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_on <= '0;
        end else begin
            led_on <= latched & {WIDTH{w_oe_active}};
        end
    end

endmodule
`default_nettype wire

// File: doc/led_shift_receiver.md
Name: led_shift_receiver

Overview:
- Receive-side counterpart of the cube's LED-driver serial link (serial_clk / serial_out / latch_enable / output_enable_n).
- Oversamples the link in the clk domain, deserializes bits into a WIDTH-bit shift register and transfers it to an output latch on latch_enable.
- Gates the latched pattern with output_enable_n and measures enabled on-time per frame.
- Used as the bench/board-level model of the driver chain and as a daisy-chained receiver on a second FPGA.

Parameters:
- WIDTH, 16, number of driver channels (shift/latch bits).
- CNT_W, 24, width of the on-time counter.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- serial_clk  input  1  link shift clock, asynchronous to clk.
- serial_in  input  1  link data, sampled on serial_clk rising edge.
- latch_enable  input  1  transfer shift register to latch on rising edge.
- output_enable_n  input  1  active-low output gate.
- serial_chain_out  output  1  MSB of shift register, for daisy chaining.
- latched  output  WIDTH  latch contents (ungated).
- led_on  output  WIDTH  latched AND NOT output_enable_n (synchronized).
- latch_strobe  output  1  one-cycle pulse when the latch updates.
- frame_error  output  1  sticky; set when a latch occurs with bit count != WIDTH.
- bit_count  output  $clog2(WIDTH+1)+1  bits shifted since last latch, saturating.
- on_cycles  output  CNT_W  clk cycles with OE active during the previous frame.

Behaviour:
- Synchronization:
  - All four link inputs pass through 2-flop synchronizers, plus a third stage for edge detection.
  - serial_in is delayed through the same depth as serial_clk, so sampled data aligns with the detected edge.
- Input timing requirement: serial_clk high and low times >= 3 clk periods each; latch_enable pulse >= 3 clk periods. Narrower pulses are undefined.
- Shift:
  - Triggered on a detected serial_clk rise (stage2=1, stage3=0).
  - shreg <= {shreg[WIDTH-2:0], serial_in_sync}; the first bit sent ends up in the MSB.
  - Latency: 3 clk cycles from the serial_clk input edge to the shreg update.
  - serial_chain_out = shreg[WIDTH-1], registered.
  - bit_count increments per shift and saturates at all-ones.
- Latch:
  - On a detected latch_enable rise: latched <= shreg; latch_strobe = 1 for exactly one cycle; bit_count <= 0.
  - frame_error <= frame_error | (bit_count != WIDTH).
- Simultaneous shift and latch in the same cycle:
  - latched captures the pre-shift shreg.
  - The shift still occurs.
  - bit_count becomes 1.
- Level-sensitive latch_enable held high does not re-latch; rising edges only.
- Output gate: led_on = latched & {WIDTH{~oe_n_sync}}, registered; 1 cycle after latched or oe_n_sync changes.
- On-time measurement:
  - run_cnt increments each cycle oe_n_sync==0 and saturates at 2^CNT_W-1.
  - On a latch event: on_cycles <= run_cnt (including the current cycle if OE is active), then run_cnt <= 0.
  - Simultaneous OE-active and latch: the current cycle is counted into the captured value, and the new run_cnt starts at 0.
- frame_error clears only on reset.
- Reset values:
  - shreg, latched, led_on, on_cycles, run_cnt, bit_count = 0.
  - latch_strobe, frame_error, serial_chain_out = 0.
  - Synchronizer stages: serial_clk and latch_enable stages = 0; output_enable_n stages = 1 (outputs off).
- Reset mid-frame discards partial shifts; the first post-reset serial_clk rise is a normal shift.
  - An input already high at reset release produces an edge only if it was 0 in stage3. Reset forces stage3 = 0, so a held-high serial_clk or latch_enable yields one event after reset.
  - Drivers must hold serial_clk and latch_enable low through reset.

Test Plan:
- WIDTH=8: shift 8'hA5 MSB-first with serial_clk period 8 clk, then pulse latch -> latched=8'hA5, latch_strobe high for 1 cycle, bit_count 8->0, frame_error=0.
- Shift 5 bits then latch -> frame_error=1 and stays 1 across a subsequent correct 8-bit frame; only reset clears it.
- Shift 8'hFF, latch, hold output_enable_n=0 for 100 clk then 1, latch again -> led_on=8'hFF during enable and 0 after (1-cycle gate latency); second latch gives on_cycles=100.
- Daisy chain: two instances, serial_chain_out of A feeds serial_in of B; shift 16 bits 16'h1234 then latch -> B.latched=8'h12, A.latched=8'h34.
- Serial_clk rise and latch_enable rise aligned at the input -> latched equals the pre-shift value, bit_count=1 after the event.
- Assert reset after 4 of 8 bits, release, send a full 8'h3C and latch -> latched=8'h3C, frame_error=0.
